mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-port memory (request/we_re/mask/valid handshake, word-addressed) between the core's instruction-fetch port and its load/store port. It allows one outstanding transaction and uses data-first priority with a bounded starvation guard for fetch. A watchdog returns an error response if memory never answers. It sits between core and a unified instruc/data memory when the design is built with a single memory macro.

Parameters:
ADDR_W, 8, word-address width driven to memory (bits [ADDR_W+1:2] of the byte address)
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch request is pending
TIMEOUT, 255, cycles in WAIT before a forced error response (≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_request  in  1  fetch request; held with i_address until i_valid
i_address  in  ADDR_W  fetch word address
i_valid  out  1  one-cycle fetch completion pulse
i_data_out  out  32  fetched word, valid with i_valid
d_request  in  1  load/store request; held with d_* fields until d_valid
d_we_re  in  1  1 = store, 0 = load
d_mask  in  4  byte enables
d_address  in  ADDR_W  data word address
d_data_in  in  32  store data
d_valid  out  1  one-cycle data completion pulse
d_data_out  out  32  load data, valid with d_valid (0 for stores)
err  out  1  high with i_valid/d_valid when the response is a timeout
m_request  out  1  one-cycle memory request pulse
m_we_re  out  1  memory write enable
m_mask  out  4  memory byte enables (4'hF for fetch)
m_address  out  ADDR_W  memory word address
m_data_in  out  32  memory write data
m_valid  in  1  memory completion, 1 cycle, ≥1 cycle after m_request
m_data_out  in  32  memory read data, valid with m_valid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; owner=NONE; streak=0; timer=0.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE: sample i_request/d_request. If none, stay.
  - Only one request: grant it.
  - Both: grant data unless streak ≥ MAX_D_STREAK, then grant fetch.
  - On grant, latch the owner's fields into m_* registers and go to ISSUE.
- Streak: +1 per data grant made while i_request=1; cleared on any fetch grant or any data grant made with i_request=0; saturates at MAX_D_STREAK.
- ISSUE: m_request=1 for exactly this cycle; m_* fields stable from ISSUE through WAIT; -> WAIT.
- WAIT: timer counts from 0. On m_valid: capture m_data_out (zero it if the transaction is a store), err=0, -> RESP. If timer reaches TIMEOUT-1 without m_valid: data=0, err=1, -> RESP.
- RESP: owner's valid=1 and err for one cycle with data; other port's valid=0; -> IDLE. Requests are ignored in RESP, which prevents re-issuing a request the requester has not yet dropped.
- Requester may present a new transaction from the cycle after its valid pulse.
- Latency: request high in IDLE at cycle t -> m_request at t+1 -> m_valid at t+1+L -> owner valid at t+2+L. Minimum 4 cycles between successive grants.
- m_valid outside WAIT is ignored, including a late response after a timeout or reset.
- Request dropped before valid: illegal. Transaction still completes and the valid pulse is still issued.
- Async reset mid-transaction: abort immediately to IDLE; no valid pulse.
- d_data_out/i_data_out hold their last value outside valid; err=0 outside RESP.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP); owner enum (NONE, INSTR, DATA); constant FETCH_MASK=4'hF.
- One sub-module, arb_watchdog: timer with clear/enable inputs and expired output, width $clog2(TIMEOUT+1).
- FSM and priority logic stay in mem_port_arbiter.

Test Plan:
- Fetch only: i_request=1, i_address=8'h10, memory L=1 returns 32'h00500093. Expect m_request at t+1 with m_mask=4'hF, m_we_re=0, m_address=8'h10; i_valid=1 with i_data_out=32'h00500093 at t+3; err=0.
- Simultaneous requests: store d_address=8'h20, d_data_in=32'hDEADBEEF, d_mask=4'b0011, plus a fetch. Expect data granted first (m_we_re=1, m_mask=4'b0011), d_valid with d_data_out=0, then fetch granted in the following IDLE.
- Starvation: d_request and i_request held continuously. Expect exactly 4 data grants, then 1 fetch grant, repeating.
- Timeout: load, memory never asserts m_valid, TIMEOUT=255. Expect d_valid=1, err=1, d_data_out=0 exactly 255 cycles after WAIT entry. A late m_valid is then ignored, with no extra valid.
- Reset mid-WAIT: rst=0 during WAIT. Expect all outputs 0 immediately, no i_valid/d_valid afterwards. After release, a new fetch completes normally.
- Back-to-back: requester keeps d_request high across d_valid with new fields the next cycle. Expect exactly one m_request per transaction, no duplicate issue.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {NONE, INSTR, DATA} owner_t;

    localparam logic [3:0] FETCH_MASK = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-state timer: counts while enabled, flags the final cycle before a
// forced error response.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_timer <= '0;
        else if (i_clear)  r_timer <= '0;
        else if (i_enable) r_timer <= r_timer + 1'b1;
    end

    assign o_expired = i_enable && (r_timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction in flight, data-first with a bounded fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_request,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_valid,
    output logic [31:0]       i_data_out,
    input  logic              d_request,
    input  logic              d_we_re,
    input  logic [3:0]        d_mask,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [31:0]       d_data_in,
    output logic              d_valid,
    output logic [31:0]       d_data_out,
    output logic              err,
    output logic              m_request,
    output logic              m_we_re,
    output logic [3:0]        m_mask,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_data_in,
    input  logic              m_valid,
    input  logic [31:0]       m_data_out
);

    localparam int STRK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_D_STREAK);

    state_t              r_state, w_next;
    owner_t              r_owner;
    logic [STRK_W-1:0]   r_streak;
    logic                r_m_request, r_m_we_re, r_i_valid, r_d_valid, r_err;
    logic [3:0]          r_m_mask;
    logic [ADDR_W-1:0]   r_m_address;
    logic [31:0]         r_m_data_in, r_i_data_out, r_d_data_out;
    logic                w_grant_i, w_grant_d, w_expired, w_done;
    logic [31:0]         w_rdata;

    // Fetch wins a tie only once data has had its quota of back-to-back grants.
    assign w_grant_i = (r_state == IDLE) && i_request && (!d_request || r_streak >= STRK_MAX);
    assign w_grant_d = (r_state == IDLE) && d_request && !w_grant_i;
    assign w_done    = (r_state == WAIT) && (m_valid || w_expired);
    assign w_rdata   = (m_valid && !r_m_we_re) ? m_data_out : '0;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != WAIT),
        .i_enable  (r_state == WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_i || w_grant_d) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (w_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= NONE;
            r_streak     <= '0;
            r_m_request  <= 1'b0;
            r_m_we_re    <= 1'b0;
            r_m_mask     <= '0;
            r_m_address  <= '0;
            r_m_data_in  <= '0;
            r_i_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_err        <= 1'b0;
            r_i_data_out <= '0;
            r_d_data_out <= '0;
        end else begin
            r_m_request <= w_grant_i || w_grant_d;
            if (w_grant_i) begin
                r_owner     <= INSTR;
                r_streak    <= '0;
                r_m_we_re   <= 1'b0;
                r_m_mask    <= FETCH_MASK;
                r_m_address <= i_address;
                r_m_data_in <= '0;
            end else if (w_grant_d) begin
                r_owner     <= DATA;
                r_m_we_re   <= d_we_re;
                r_m_mask    <= d_mask;
                r_m_address <= d_address;
                r_m_data_in <= d_data_in;
                if (!i_request)               r_streak <= '0;
                else if (r_streak != STRK_MAX) r_streak <= r_streak + 1'b1;
            end else if (r_state == RESP) begin
                r_owner <= NONE;
            end

            r_i_valid <= w_done && (r_owner == INSTR);
            r_d_valid <= w_done && (r_owner == DATA);
            r_err     <= w_done && !m_valid;
            if (w_done && r_owner == INSTR) r_i_data_out <= w_rdata;
            if (w_done && r_owner == DATA)  r_d_data_out <= w_rdata;
        end
    end

    assign m_request  = r_m_request;
    assign m_we_re    = r_m_we_re;
    assign m_mask     = r_m_mask;
    assign m_address  = r_m_address;
    assign m_data_in  = r_m_data_in;
    assign i_valid    = r_i_valid;
    assign d_valid    = r_d_valid;
    assign err        = r_err;
    assign i_data_out = r_i_data_out;
    assign d_data_out = r_d_data_out;

endmodule
